// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit queue: scheduler states and the
// default frame length at the system baud rate.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } tx_state_t;

    // start + 8 data + stop bits at the system baud rate, in clock cycles
    localparam int DEFAULT_FRAME_CYCLES = 10416;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a combinational head view; the caller guarantees
// push only when not full and pop only when not empty.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("byte_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit scheduler between the store path and the uart: queues bytes and
// hands one to the uart every FRAME_CYCLES, stalling stores while full.
module uart_tx_queue
    import uart_tx_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   stall,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   idle,
    output logic                   uart_wr,
    output logic [7:0]             uart_dat
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
    // SEND occupies one cycle and the final WAIT cycle sees timer == 0.
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(FRAME_CYCLES - 2);

    if (FRAME_CYCLES < 2) begin : g_bad_frame
        $error("uart_tx_queue: FRAME_CYCLES must be at least 2");
    end

    tx_state_t     state;
    tx_state_t     next_state;
    logic [TW-1:0] timer;
    logic          queued;
    logic          push;
    logic          pop;
    logic          next_uart_wr;
    logic [7:0]    head;

    assign queued = (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign stall  = wr_en & full;
    assign push   = wr_en & ~full;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_data),
        .dout  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
        end else begin
            state   <= next_state;
            uart_wr <= next_uart_wr;
            if (state == SEND) begin
                timer <= TIMER_RELOAD;
            end else if (state == WAIT && timer != '0) begin
                timer <= timer - TW'(1);
            end
            if (pop) begin
                uart_dat <= head;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (queued) next_state = SEND;
            SEND:    next_state = WAIT;
            WAIT:    if (timer == '0) next_state = queued ? SEND : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The pop that loads uart_dat happens on the edge entering SEND, so the
    // byte and the pulse appear together.
    always_comb begin
        pop          = 1'b0;
        next_uart_wr = (next_state == SEND);
        unique case (state)
            IDLE:    pop = queued;
            WAIT:    pop = (timer == '0) && queued;
            default: pop = 1'b0;
        endcase
    end

    assign idle = (state == IDLE) && !queued;

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit scheduler for the serial port. It sits between the EX-stage store path and the `uart` module. Stores to `UART_ADDR` push bytes into a FIFO. The block releases them to `uart` one at a time, spaced by a fixed frame interval, and raises a pipeline stall when the FIFO is full. This lets back-to-back `putchar` stores run without losing characters.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `FRAME_CYCLES`, 10416: clock cycles reserved per transmitted byte (start + 8 data + stop at the system baud rate); must be at least 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: a store to `UART_ADDR` is in EX this cycle (driven from `uart_we`).
- `wr_data` in 8: byte to send (`mem_write_value_EX[7:0]`).
- `stall` out 1: combinational, equal to `wr_en & full`; the pipeline freezes IF/ID/EX and holds the store.
- `full` out 1: `count == DEPTH`.
- `count` out $clog2(DEPTH)+1: bytes queued, excluding any byte already handed to `uart`.
- `idle` out 1: queue empty and state is IDLE; used by halt logic to drain output.
- `uart_wr` out 1: one-cycle pulse to `uart.uart_wr_i`.
- `uart_dat` out 8: byte to `uart.uart_dat_i`; valid during the pulse and held until the next pulse.

## Operation
- Push: on a clock edge where `wr_en & ~full`, `wr_data` is written at the write pointer and the write pointer increments, wrapping modulo `DEPTH`.
- Stalled push: `wr_en & full` stores nothing and changes nothing. The held store retries every cycle until space frees.
- FSM states:
  - IDLE: `uart_wr` = 0. If `count != 0`, go to SEND and pop the head entry into `uart_dat`.
  - SEND: `uart_wr` = 1 for exactly one cycle. Then go to WAIT with `timer` = `FRAME_CYCLES - 2`.
  - WAIT: `uart_wr` = 0. If `timer != 0`, decrement it. If `timer == 0`: go to SEND with a pop when `count != 0`, otherwise go to IDLE.
- Push and pop on the same edge leave `count` unchanged, and both pointers advance.
- A push to a full FIFO that coincides with a pop is still refused, because `full` is computed from registered `count`. It is accepted on the next cycle.
- Count width arithmetic: `count` is one bit wider than the pointers so that full and empty are distinguishable. Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- Reset, including mid-frame or mid-pulse, takes effect at the next edge:
  - state goes to IDLE;
  - pointers, `count` and `timer` go to 0;
  - `uart_dat` goes to 0 and `uart_wr` goes to 0;
  - queued bytes are discarded;
  - `uart` is reset by the same `rst`.
- Reset values of outputs: `uart_wr` 0, `uart_dat` 0, `count` 0, `full` 0, `idle` 1, `stall` equal to `wr_en & 0`, i.e. 0.

## Timing
- Latency: `wr_en` in cycle t into an empty IDLE queue gives `count` = 1 in cycle t+1 and `uart_wr` = 1 in cycle t+2.
- Spacing: consecutive `uart_wr` pulses are exactly `FRAME_CYCLES` cycles apart while the queue is non-empty.
- `stall` is the only combinational output. All others are registered.
- `idle` rises the cycle after the final WAIT expires with an empty queue.

## Structure
- Shared package `uart_tx_pkg`: state enumeration (IDLE, SEND, WAIT) and a default frame-cycles constant. `UART_ADDR` stays in the existing global defines.
- One sub-module, `byte_fifo`:
  - synchronous, 8-bit wide, `DEPTH` entries;
  - ports `push`, `pop`, `din`, `dout`, `count`;
  - `dout` shows the head entry combinationally.
- The FSM and `timer` (width `$clog2(FRAME_CYCLES)`) live in `uart_tx_queue`.
- Integration in the CPU top:
  - `stall` gates the IF/ID/EX register updates and forces a bubble into RW;
  - `uart_wr` and `uart_dat` replace the direct `uart_we` and `uart_IN_data` hookup.

## Test plan
All scenarios use `DEPTH` = 4 and `FRAME_CYCLES` = 8.
- Single byte: `wr_en` with 0x41 at cycle 10 -> `uart_wr` pulse at cycle 12 with `uart_dat` = 0x41; `idle` = 1 from cycle 20.
- Burst of 3 bytes on consecutive cycles (0x61, 0x62, 0x63) -> pulses at cycles 12, 20, 28 carrying those bytes in that order; `count` peaks at 2; `stall` never asserted.
- Overflow: 6 consecutive writes held under `stall` -> `stall` high exactly while `full` and `wr_en` are both high; all 6 bytes emerge in order with no loss or duplicate.
- Pointer wrap: 9 bytes written over time, each accepted as space frees -> output order preserved across the wrap from index 3 to index 0.
- Reset mid-WAIT with 2 bytes queued -> next cycle `uart_wr` = 0, `count` = 0, `idle` = 1; no further pulses until a new write arrives.
- Push and pop on the same edge with `count` = 2 -> `count` stays 2 and the FIFO contents stay ordered.
